dut_arbiter: RTL and testbench
==============================

# dut_arbiter

Round-robin arbiter and sequencer that shares one `dut` datapath instance among `NUM_REQ` requesters. It accepts a single-word request from one requester and drives it onto `dut.data_in`. After the fixed pipeline latency it captures `dut.data_out` and returns the result to the same requester over a valid/ready response channel. It sits between the requester agents and `dut_inst`, and only one transaction is in flight at a time.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_W`, 8: datapath width, matching `dut` data ports.
- `DUT_LATENCY`, 2: cycles from `dut.data_in` change to valid `dut.data_out`, ≥1.
- `TIMEOUT_CYC`, 64: response-stall limit, used only with `DUT_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_data`  in  NUM_REQ*DATA_W  request words; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `rsp_valid`  out  NUM_REQ  one-hot response valid.
- `rsp_data`  out  DATA_W  response word, shared by all requesters.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `dut_data_in`  out  DATA_W  drives `dut.data_in`.
- `dut_data_out`  in  DATA_W  from `dut.data_out`.
- `busy`  out  1  high in any state other than IDLE.
- `err_timeout`  out  1  one-cycle pulse on a dropped response; tied 0 without the macro.

## Operation
- FSM states: IDLE → WAIT → RESP → IDLE.
- **IDLE**
  - Round-robin search over `req_valid`, starting at `last_grant+1` and wrapping modulo NUM_REQ.
  - The winner g gets `req_ready[g]=1`, combinationally and in IDLE only.
  - Accept occurs when `req_valid[g] && req_ready[g]`. On accept: `dut_data_in <= req_data[g]`, `grant <= g`, `cnt <= DUT_LATENCY-1`, go to WAIT.
  - If no request is valid, nothing is granted.
- **WAIT**
  - `dut_data_in` is held stable.
  - When `cnt==0`: `rsp_data <= dut_data_out`, go to RESP. Otherwise `cnt <= cnt-1`.
- **RESP**
  - `rsp_valid[grant]=1`; `rsp_data` is held.
  - On `rsp_ready[grant]`: `last_grant <= grant`, `dut_data_in <= 0`, go to IDLE.
  - `rsp_ready` on any other index, or outside RESP, is ignored.
- A requester may drop `req_valid` before accept. This is legal and no transaction starts.
- Counter width is `$clog2(DUT_LATENCY+1)`. The grant index is `$clog2(NUM_REQ)` bits wide.

## Timing
- Reset (synchronous, at the edge where `rst=1`):
  - State = IDLE and `last_grant=NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `dut_data_in=0`, `busy=0`, `err_timeout=0`.
- Reset mid-transaction abandons the transaction with no response. `dut_data_in` returns to 0 at the same edge.
- Latency:
  - Accept at edge E.
  - `dut_data_in` is valid after E.
  - `dut_data_out` is captured at edge E+DUT_LATENCY.
  - `rsp_valid` is high from E+DUT_LATENCY.
- Throughput:
  - With `rsp_ready` already high, the response completes at E+DUT_LATENCY+1.
  - The next accept is possible at E+DUT_LATENCY+2.
  - Minimum occupancy is DUT_LATENCY+2 cycles per transaction.
- Simultaneous requests: exactly one grant per IDLE cycle. Priority rotates after each completed (or dropped) response.

## Configuration
- Macro: `DUT_ARB_TIMEOUT_EN`.
- Defined:
  - In RESP, a stall counter increments each cycle that `rsp_ready[grant]` is low.
  - When the count reaches TIMEOUT_CYC, the response is dropped: `err_timeout=1` for one cycle, `last_grant <= grant`, go to IDLE.
  - The stall counter clears on every RESP entry.
- Undefined: RESP waits indefinitely and `err_timeout` is tied 0.

## Structure
- Package `dut_arb_pkg`:
  - `state_t` enum (IDLE, WAIT, RESP).
  - Default constants for DATA_W, DUT_LATENCY and TIMEOUT_CYC.
- Sub-module `rr_arbiter`:
  - Combinational rotate-priority encoder.
  - Inputs: request vector, `last_grant`. Outputs: one-hot grant, grant index.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles → all outputs 0 and `busy=0`. First request from requester 3 alone → `req_ready=4'b1000`.
- **Single transaction:** NUM_REQ=4, DUT_LATENCY=2; requester 1 sends 8'hA5 with `rsp_ready` high → `rsp_valid=4'b0010` two edges after accept, `rsp_data` equals the `dut` result for A5, IDLE after 1 more cycle.
- **Round-robin fairness:** all four requesters hold `req_valid` continuously (A5, 5A, 3C, C3) → grants in order 0, 1, 2, 3, 0, with spacing DUT_LATENCY+2 cycles.
- **Response backpressure:** `rsp_ready` is held low for 10 cycles → `rsp_valid` and `rsp_data` are held stable, no new `req_ready`, `busy=1` throughout.
- **Mid-operation reset:** assert `rst` during WAIT → no `rsp_valid` ever, `dut_data_in=0`, priority restarts at requester 0.
- **Timeout (macro on):** TIMEOUT_CYC=64 and `rsp_ready` never asserted → `err_timeout` pulses exactly once, 64 cycles after RESP entry, then FSM returns to IDLE.

Source files
------------

// File: rtl/dut_arb_pkg.sv
// dut_arb_pkg: FSM state type and default parameters shared by dut_arbiter and its sub-modules
package dut_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DUT_LATENCY = 2;
  localparam int DEF_TIMEOUT_CYC = 64;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder (in: req, last_grant; out: one-hot gnt, grant idx), search starts at last_grant+1
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] k;
  always_comb begin
    gnt = '0;
    idx = '0;
    k = '0;
    for (int i = N; i > 0; i--) begin
      k = IW'((int'(last_grant) + i) % N);
      if (req[k]) begin
        gnt = N'(1) << k;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/dut_arbiter.sv
// dut_arbiter: round-robin sequencer sharing one dut (clk, rst, req_valid/req_data/req_ready, rsp_valid/rsp_data/rsp_ready, dut_data_in/dut_data_out, busy, err_timeout); option DUT_ARB_TIMEOUT_EN drops stalled responses
module dut_arbiter
  import dut_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DUT_LATENCY = DEF_DUT_LATENCY,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         dut_data_in,
  input  logic [DATA_W-1:0]         dut_data_out,
  output logic                      busy,
  output logic                      err_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DUT_LATENCY + 1);
  state_t state, state_nx;
  logic [IW-1:0] grant, last_grant, win_idx;
  logic [NUM_REQ-1:0] win;
  logic [CW-1:0] cnt;
  logic accept, done, drop;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid),
    .last_grant(last_grant),
    .gnt(win),
    .idx(win_idx)
  );
  assign accept = state == IDLE && |win;
  assign done = state == RESP && rsp_ready[grant];
`ifdef DUT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] stall;
  assign drop = state == RESP && !rsp_ready[grant] && stall == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    stall <= (rst || state != RESP) ? '0 : stall + 1'b1;
`else
  assign drop = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? WAIT : IDLE) :
               state == WAIT ? (cnt == '0 ? RESP : WAIT) :
               (done || drop) ? IDLE : RESP;
  always_comb begin
    req_ready = state == IDLE ? win : '0;
    rsp_valid = state == RESP ? NUM_REQ'(1) << grant : '0;
    busy = state != IDLE;
    err_timeout = drop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_data_in <= '0;
      rsp_data <= '0;
      grant <= '0;
      cnt <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        dut_data_in <= req_data[win_idx*DATA_W +: DATA_W];
        grant <= win_idx;
        cnt <= CW'(DUT_LATENCY - 1);
      end
      if (state == WAIT) begin
        if (cnt == '0) rsp_data <= dut_data_out;
        else cnt <= cnt - 1'b1;
      end
      if (done || drop) begin
        last_grant <= grant;
        dut_data_in <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dut_arbiter.sv
// tb_dut_arbiter: self-checking bench for dut_arbiter with a behavioural dut and round-robin reference model
module tb_dut_arbiter;
  logic clk = 0, rst = 1;
  logic [3:0] req_valid = 0, rsp_ready = 0;
  logic [31:0] req_data = 0;
  logic [3:0] req_ready, rsp_valid;
  logic [7:0] rsp_data, dut_data_in, dut_data_out, dq;
  logic busy, err_timeout;
  int n_cmp = 0, n_bad = 0, last_m = 3, cyc = 0;
  int acc[5];
  dut_arbiter #(.NUM_REQ(4), .DATA_W(8), .DUT_LATENCY(2), .TIMEOUT_CYC(64)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .dut_data_in(dut_data_in), .dut_data_out(dut_data_out), .busy(busy), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] f(input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h5A;
  endfunction
  always @(posedge clk) dq <= f(dut_data_in);
  assign dut_data_out = dq;
  function automatic int pick(input logic [3:0] v);
    for (int i = 1; i <= 4; i++) if (v[(last_m + i) % 4]) return (last_m + i) % 4;
    return -1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input logic [3:0] v, input logic [31:0] dv, input int stall, input bit hold, output int acc_cyc);
    int g, k;
    logic [7:0] d;
    req_valid = v;
    req_data = dv;
    #1;
    g = pick(v);
    d = dv[g*8 +: 8];
    chk("grant", req_ready, 32'(1 << g));
    chk("busy_idle", busy, 0);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) req_valid = 0;
    chk("busy_wait", busy, 1);
    chk("din", dut_data_in, d);
    k = 0;
    while (rsp_valid == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 2);
    chk("rsp_valid", rsp_valid, 32'(1 << g));
    chk("rsp_data", rsp_data, f(d));
    chk("din_hold", dut_data_in, d);
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 4'($urandom) & ~4'(1 << g);
      req_valid = 4'($urandom);
      @(negedge clk);
      chk("bp_valid", rsp_valid, 32'(1 << g));
      chk("bp_data", rsp_data, f(d));
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_err", err_timeout, 0);
    end
    rsp_ready = 4'(1 << g) | 4'($urandom);
    req_valid = hold ? v : 4'b0;
    @(negedge clk);
    rsp_ready = 0;
    chk("idle_busy", busy, 0);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_din", dut_data_in, 0);
    last_m = g;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int a, k, n, p;
    logic [3:0] seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_din", dut_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst = 0;
    txn(4'b1000, $urandom, 0, 0, a);
    txn(4'b0010, 32'h0000A500, 0, 0, a);
    txn(4'b0101, $urandom, 10, 0, a);
    req_valid = 4'b0001;
    #1;
    chk("drop_ready", req_ready, 32'(1 << pick(4'b0001)));
    req_valid = 0;
    @(negedge clk);
    chk("drop_busy", busy, 0);
    req_valid = 4'b0100;
    req_data = $urandom;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("mid_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_din", dut_data_in, 0);
    last_m = 3;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("mid_rst_no_rsp", seen, 0);
    for (int i = 0; i < 5; i++) begin
      chk("fair_order", pick(4'b1111), i % 4);
      txn(4'b1111, 32'hC33C5AA5, 0, 1, acc[i]);
      if (i > 0) chk("fair_spacing", acc[i] - acc[i-1], 4);
    end
    req_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      txn(4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3), 1'($urandom), a);
    req_valid = 0;
    @(negedge clk);
`ifdef DUT_ARB_TIMEOUT_EN
    req_valid = 4'b0001;
    rsp_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (rsp_valid == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n = 0;
    p = 0;
    while (busy && n < 200) begin
      p += int'(err_timeout);
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 64);
    chk("to_pulses", p, 1);
    chk("to_idle_rsp", rsp_valid, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
